// File: rtl/ife_pkg.sv
// ife_pkg: shared constants, block record and receiver state encoding for
// the IFE block-dispatch receiver.
package ife_pkg;

    localparam int          ID_W            = 8;
    localparam int          INSTR_PER_BLOCK = 4;
    localparam logic [31:0] NOP_INSN        = 32'h0000_0013;  // addi x0,x0,0

    // One dispatched block: its ID plus the packed instruction words,
    // element 0 in the least significant 32 bits (issued first).
    typedef struct packed {
        logic [ID_W-1:0]                   id;
        logic [INSTR_PER_BLOCK-1:0][31:0]  data;
    } ife_block_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ife_block_fifo.sv
// ife_block_fifo: DEPTH-entry block store. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate occupancy counter.
module ife_block_fifo
    import ife_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  ife_block_t              wdata_i,
    input  logic                    pop_i,
    output ife_block_t              head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int PW = $clog2(DEPTH);

    ife_block_t  mem_q [DEPTH];
    logic [PW:0] wr_ptr_q;
    logic [PW:0] rd_ptr_q;

    // Pointer advance; the caller only pushes when not full and pops when not empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    // Block storage; contents are meaningless while the slot is empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/ife_block_receiver.sv
// ife_block_receiver: core-side responder for IFE block dispatch. Buffers
// blocks, issues the head block one instruction at a time, counts retirements
// and holds commit_ready until the IFE acknowledges.
// Optional build macro IFE_RX_SKIP_NOP_EN: NOP words are retired internally
// instead of being offered to the core.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high; while instr_valid is high and instr_ready low,
// instr_data/instr_idx/instr_block_id hold their values. A commit transfers
// on a rising edge where commit_ready and commit_ack are both high.
module ife_block_receiver
    import ife_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         block_valid,
    input  logic [ID_W-1:0]              block_id,
    input  logic [INSTR_PER_BLOCK*32-1:0] block_data_in,
    output logic                         busy,
    output logic                         instr_valid,
    output logic [31:0]                  instr_data,
    output logic [1:0]                   instr_idx,
    output logic [ID_W-1:0]              instr_block_id,
    input  logic                         instr_ready,
    input  logic                         retire_valid,
    output logic                         commit_ready,
    output logic [ID_W-1:0]              commit_block_id,
    input  logic                         commit_ack,
    output logic                         err_overflow,
    output logic                         err_retire,
    output rx_state_e                    dbg_state
);
    localparam int PW = $clog2(DEPTH);

    rx_state_e   state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  issued_q, issued_d;
    logic [2:0]  retired_q, retired_d;
    logic        err_overflow_q, err_overflow_d;
    logic        err_retire_q, err_retire_d;

    ife_block_t  push_blk;
    ife_block_t  head;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [PW:0] fifo_count;

    logic [31:0] head_word;
    logic        last_idx;
    logic        retire_ok;
    logic        offer;
    logic        advance;

    assign push_blk.id   = block_id;
    assign push_blk.data = block_data_in;
    // Full is decided from registered pointers, so a same-cycle pop never frees a slot.
    assign fifo_push     = block_valid && !fifo_full;

    ife_block_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (push_blk),
        .pop_i   (fifo_pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign busy         = fifo_full;
    assign err_overflow = err_overflow_q;
    assign err_retire   = err_retire_q;
    assign dbg_state    = state_q;
    assign head_word    = head.data[idx_q];
    assign last_idx     = (idx_q == 2'(INSTR_PER_BLOCK-1));

    // State, counters and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            issued_q       <= '0;
            retired_q      <= '0;
            err_overflow_q <= 1'b0;
            err_retire_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            issued_q       <= issued_d;
            retired_q      <= retired_d;
            err_overflow_q <= err_overflow_d;
            err_retire_q   <= err_retire_d;
        end
    end

    // Next state, counter updates and the instruction/commit outputs.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        issued_d        = issued_q;
        retired_d       = retired_q;
        err_overflow_d  = err_overflow_q | (block_valid && fifo_full);
        err_retire_d    = err_retire_q;
        instr_valid     = 1'b0;
        instr_data      = '0;
        instr_idx       = '0;
        instr_block_id  = '0;
        commit_ready    = 1'b0;
        commit_block_id = '0;
        fifo_pop        = 1'b0;
        offer           = 1'b0;
        advance         = 1'b0;

        // Only instructions accepted on earlier edges are outstanding.
        retire_ok = retire_valid && (state_q == ISSUE || state_q == DRAIN) &&
                    (retired_q < issued_q);
        if (retire_valid && !retire_ok) err_retire_d = 1'b1;
        if (retire_ok)                  retired_d    = retired_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = ISSUE;
                    idx_d     = '0;
                    issued_d  = '0;
                    retired_d = '0;
                end
            end
            ISSUE: begin
`ifdef IFE_RX_SKIP_NOP_EN
                if (head_word == NOP_INSN) begin
                    advance   = 1'b1;
                    retired_d = retired_d + 3'd1;
                end else begin
                    offer = 1'b1;
                end
`else
                offer = 1'b1;
`endif
                if (offer) begin
                    instr_valid    = 1'b1;
                    instr_data     = head_word;
                    instr_idx      = idx_q;
                    instr_block_id = head.id;
                    advance        = instr_ready;
                end
                if (advance) begin
                    issued_d = issued_q + 3'd1;
                    idx_d    = idx_q + 2'd1;
                    if (last_idx) begin
                        state_d = (retired_d == 3'(INSTR_PER_BLOCK)) ? COMMIT : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (retired_d == 3'(INSTR_PER_BLOCK)) state_d = COMMIT;
            end
            COMMIT: begin
                commit_ready    = 1'b1;
                commit_block_id = head.id;
                if (commit_ack) begin
                    fifo_pop  = 1'b1;
                    idx_d     = '0;
                    issued_d  = '0;
                    retired_d = '0;
                    state_d   = (fifo_count > (PW+1)'(1)) ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ife_block_receiver.sv
// tb_ife_block_receiver: directed and randomized bench for ife_block_receiver.
// Build with +define+IFE_RX_SKIP_NOP_EN to also cover NOP skipping.
`timescale 1ns/1ps
module tb_ife_block_receiver;
    import ife_pkg::*;

    localparam int DEPTH = 2;
    localparam int TW    = ID_W + 2 + 32;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          block_valid;
    logic [ID_W-1:0]               block_id;
    logic [INSTR_PER_BLOCK*32-1:0] block_data_in;
    logic                          busy;
    logic                          instr_valid;
    logic [31:0]                   instr_data;
    logic [1:0]                    instr_idx;
    logic [ID_W-1:0]               instr_block_id;
    logic                          instr_ready;
    logic                          retire_valid;
    logic                          commit_ready;
    logic [ID_W-1:0]               commit_block_id;
    logic                          commit_ack;
    logic                          err_overflow;
    logic                          err_retire;
    rx_state_e                     dbg_state;

    ife_block_receiver #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .block_valid     (block_valid),
        .block_id        (block_id),
        .block_data_in   (block_data_in),
        .busy            (busy),
        .instr_valid     (instr_valid),
        .instr_data      (instr_data),
        .instr_idx       (instr_idx),
        .instr_block_id  (instr_block_id),
        .instr_ready     (instr_ready),
        .retire_valid    (retire_valid),
        .commit_ready    (commit_ready),
        .commit_block_id (commit_block_id),
        .commit_ack      (commit_ack),
        .err_overflow    (err_overflow),
        .err_retire      (err_retire),
        .dbg_state       (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: blocks as queues of expected transfers.
    logic [TW-1:0]   exp_q[$];         // {id, idx, word} in issue order
    logic [ID_W-1:0] exp_commit_q[$];  // block IDs in commit order
    int              need_q[$];        // core-visible instructions per block
    int              model_occ;
    int              acc_cnt;          // head-block instructions accepted so far
    int              ret_cnt;          // head-block retires issued so far
    bit              err_ovf_exp;
    bit              err_ret_exp;
    bit              hold_v;
    logic [TW-1:0]   hold_t;
    bit              commit_prev;

    task automatic model_clear();
        exp_q.delete();
        exp_commit_q.delete();
        need_q.delete();
        model_occ   = 0;
        acc_cnt     = 0;
        ret_cnt     = 0;
        err_ovf_exp = 0;
        err_ret_exp = 0;
        hold_v      = 0;
        hold_t      = '0;
        commit_prev = 0;
    endtask

    task automatic model_accept(input logic [ID_W-1:0] id, input logic [127:0] data);
        int n = 0;
        logic [31:0] w;
        for (int i = 0; i < INSTR_PER_BLOCK; i++) begin
            w = data[i*32 +: 32];
`ifdef IFE_RX_SKIP_NOP_EN
            if (w == NOP_INSN) continue;
`endif
            exp_q.push_back({id, 2'(i), w});
            n++;
        end
        exp_commit_q.push_back(id);
        need_q.push_back(n);
        model_occ++;
    endtask

    // One clock cycle: observe outputs, drive inputs, advance the model.
    // ret_mode: 0 = no retire, 1 = retire only if one is outstanding, 2 = force.
    task automatic cycle(input bit push, input logic [ID_W-1:0] id, input logic [127:0] data,
                         input bit rdy, input int ret_mode, input bit ack);
        logic [TW-1:0] obs;
        logic [TW-1:0] exp;
        bit hs, ret, ackd, acc_push;
        obs = {instr_block_id, instr_idx, instr_data};
        hs  = instr_valid && rdy;
        if (hold_v) begin
            checks++;
            if (instr_valid !== 1'b1 || obs !== hold_t) begin
                errors++;
                $display("FAIL stall_stable: got valid=%0b %h, expected valid=1 %h", instr_valid, obs, hold_t);
            end
        end
        hold_v = instr_valid && !rdy;
        hold_t = obs;
        if (hs) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL instr_extra: got %h, expected no instruction", obs);
            end else begin
                exp = exp_q.pop_front();
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL instr_xfer: got %h, expected %h", obs, exp);
                end
            end
        end
        if (commit_prev) begin
            checks++;
            if (commit_ready !== 1'b1) begin
                errors++;
                $display("FAIL commit_hold: got commit_ready=%0b, expected 1", commit_ready);
            end
        end
        if (commit_ready === 1'b1) begin
            checks++;
            if (exp_commit_q.size() == 0) begin
                errors++;
                $display("FAIL commit_extra: got id %h, expected no commit", commit_block_id);
            end else if (commit_block_id !== exp_commit_q[0] || acc_cnt != need_q[0] || ret_cnt != need_q[0]) begin
                errors++;
                $display("FAIL commit: got id %h acc=%0d ret=%0d, expected id %h with %0d retired",
                         commit_block_id, acc_cnt, ret_cnt, exp_commit_q[0], need_q[0]);
            end
        end
        ackd        = ack && (commit_ready === 1'b1);
        commit_prev = (commit_ready === 1'b1) && !ack;
        case (ret_mode)
            1:       ret = (acc_cnt > ret_cnt);
            2:       ret = 1'b1;
            default: ret = 1'b0;
        endcase
        if (ret && !(acc_cnt > ret_cnt)) err_ret_exp = 1;
        acc_push = push && (model_occ < DEPTH);
        if (push && !acc_push) err_ovf_exp = 1;

        block_valid   = push;
        block_id      = id;
        block_data_in = data;
        instr_ready   = rdy;
        retire_valid  = ret;
        commit_ack    = ack;
        @(posedge clk);
        #1;
        block_valid  = 1'b0;
        retire_valid = 1'b0;
        commit_ack   = 1'b0;

        if (hs) acc_cnt++;
        if (ret && acc_cnt - (hs ? 1 : 0) > ret_cnt) ret_cnt++;
        if (ackd) begin
            void'(exp_commit_q.pop_front());
            void'(need_q.pop_front());
            model_occ--;
            acc_cnt = 0;
            ret_cnt = 0;
        end
        if (acc_push) model_accept(id, data);

        checks++;
        if (busy !== (model_occ == DEPTH) || err_overflow !== err_ovf_exp || err_retire !== err_ret_exp) begin
            errors++;
            $display("FAIL status: got busy=%0b ovf=%0b ret=%0b, expected busy=%0b ovf=%0b ret=%0b",
                     busy, err_overflow, err_retire, model_occ == DEPTH, err_ovf_exp, err_ret_exp);
        end
    endtask

    task automatic drain(input int budget, input int period);
        int n = 0;
        while ((exp_q.size() != 0 || exp_commit_q.size() != 0) && n < budget) begin
            cycle(1'b0, '0, '0, (n % period) == 0, 1, 1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_commit_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d instr / %0d commits pending, expected 0", exp_q.size(), exp_commit_q.size());
        end
    endtask

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        block_valid = 0; block_id = '0; block_data_in = '0;
        instr_ready = 0; retire_valid = 0; commit_ack = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, instr_valid, instr_data, instr_idx, instr_block_id, commit_ready,
             commit_block_id, err_overflow, err_retire} !== '0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs or state %0d, expected all 0 / IDLE", dbg_state);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_block();
        logic [127:0] d = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
        int n = 0;
        cycle(1'b1, 8'h05, d, 1'b1, 0, 1'b0);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_1: got instr_valid=%0b, expected 0", instr_valid);
        end
        cycle(1'b0, '0, '0, 1'b1, 0, 1'b0);
        checks++;
        if (instr_valid !== 1'b1 || instr_idx !== 2'd0 || instr_data !== 32'hA0A0_0000) begin
            errors++;
            $display("FAIL latency_2: got valid=%0b idx=%0d data=%h, expected 1 0 a0a00000", instr_valid, instr_idx, instr_data);
        end
        while (commit_ready !== 1'b1 && n < 20) begin
            cycle(1'b0, '0, '0, 1'b1, 1, 1'b0);
            n++;
        end
        checks++;
        if (commit_ready !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_commit: got commit_ready=%0b pending=%0d, expected 1 0", commit_ready, exp_q.size());
        end
        repeat (3) cycle(1'b0, '0, '0, 1'b1, 0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 0, 1'b1);
        checks++;
        if (commit_ready !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE || exp_commit_q.size() != 0) begin
            errors++;
            $display("FAIL single_after_ack: got commit_ready=%0b busy=%0b state=%0d, expected 0 0 IDLE", commit_ready, busy, dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 8'h01, rand_block(), 1'b0, 0, 1'b0);
        cycle(1'b1, 8'h02, rand_block(), 1'b0, 0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_full: got %0b, expected 1", busy);
        end
        cycle(1'b1, 8'h03, rand_block(), 1'b0, 0, 1'b0);
        checks++;
        if (err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag: got %0b, expected 1", err_overflow);
        end
        drain(200, 1);
    endtask

    task automatic test_throttle();
        cycle(1'b1, 8'h33, rand_block(), 1'b0, 0, 1'b0);
        drain(200, 3);
    endtask

    task automatic test_bad_retire();
        int n = 0;
        cycle(1'b1, 8'h44, rand_block(), 1'b0, 0, 1'b0);
        while (instr_valid !== 1'b1 && n < 10) begin
            cycle(1'b0, '0, '0, 1'b0, 0, 1'b0);
            n++;
        end
        cycle(1'b0, '0, '0, 1'b0, 2, 1'b0);
        checks++;
        if (err_retire !== 1'b1) begin
            errors++;
            $display("FAIL bad_retire: got err_retire=%0b, expected 1", err_retire);
        end
        drain(200, 1);
    endtask

    task automatic test_random();
        int sent = 0;
        int n = 0;
        bit p;
        while ((sent < 16 || exp_q.size() != 0 || exp_commit_q.size() != 0) && n < 3000) begin
            p = (sent < 16) && ($urandom_range(0, 2) == 0);
            cycle(p, ID_W'($urandom), rand_block(), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            if (p) sent++;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_commit_q.size() != 0) begin
            errors++;
            $display("FAIL random_timeout: got %0d instr / %0d commits pending, expected 0", exp_q.size(), exp_commit_q.size());
        end
    endtask

    task automatic test_reset_in_drain();
        int n = 0;
        cycle(1'b1, 8'h66, rand_block(), 1'b1, 0, 1'b0);
        while (acc_cnt < INSTR_PER_BLOCK && n < 20) begin
            cycle(1'b0, '0, '0, 1'b1, 0, 1'b0);
            n++;
        end
        cycle(1'b0, '0, '0, 1'b0, 1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1, 1'b0);
        checks++;
        if (dbg_state !== DRAIN || ret_cnt != 2) begin
            errors++;
            $display("FAIL pre_reset_drain: got state=%0d retired=%0d, expected DRAIN 2", dbg_state, ret_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, instr_valid, instr_data, instr_idx, instr_block_id, commit_ready,
             commit_block_id, err_overflow, err_retire} !== '0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL async_reset: got nonzero outputs or state %0d, expected all 0 / IDLE", dbg_state);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        cycle(1'b1, 8'h77, rand_block(), 1'b1, 0, 1'b0);
        drain(200, 1);
    endtask

`ifdef IFE_RX_SKIP_NOP_EN
    task automatic test_nop_skip();
        logic [127:0] d = {NOP_INSN, NOP_INSN, 32'hB1B1_0001, NOP_INSN};
        cycle(1'b1, 8'h88, d, 1'b0, 0, 1'b0);
        drain(200, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_throttle();
        test_bad_retire();
        test_random();
        test_reset_in_drain();
`ifdef IFE_RX_SKIP_NOP_EN
        test_nop_skip();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
